// File: rtl/strand_fsm_param.sv
// Per-strand issue controller: gates issue requests, walks vector transfers
// lane by lane with a strided offset, and inserts RAW/cache-miss stalls.
module strand_fsm_param #(
  parameter int NUM_LANES     = 16,
  parameter int LANE_W        = $clog2(NUM_LANES),
  parameter int STRIDE_W      = 10,
  parameter int LOAD_LATENCY  = 2,
  parameter int ARITH_LATENCY = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instruction_i,
  input  logic              instruction_valid_i,
  input  logic [31:0]       pc_i,
  input  logic              grant_i,
  input  logic              flush_i,
  input  logic              suspend_strand_i,
  input  logic              resume_strand_i,
  input  logic [LANE_W-1:0] rollback_reg_lane_i,
  input  logic [31:0]       rollback_strided_offset_i,
  output logic              issue_request_o,
  output logic              next_instruction_o,
  output logic [LANE_W-1:0] reg_lane_select_o,
  output logic [31:0]       strided_offset_o,
  output logic [31:0]       pc_o,
  output logic [31:0]       instruction_o,
  output logic [2:0]        strand_state_o
);

  localparam int MAX_LAT = (LOAD_LATENCY > ARITH_LATENCY) ? LOAD_LATENCY : ARITH_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic [2:0] {
    NORMAL     = 3'd0,
    VLOAD      = 3'd1,
    VSTORE     = 3'd2,
    RAW_WAIT   = 3'd3,
    CACHE_WAIT = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [31:0]       offset_q, offset_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic        fmt_a, fmt_b, fmt_c, arith_mc, is_load, vec;
  logic        last, will_issue, in_vec;
  logic [31:0] stride;

  always_comb begin
    fmt_a    = instruction_i[31:29] == 3'b110;
    fmt_b    = !instruction_i[31];
    fmt_c    = instruction_i[31:30] == 2'b10;
    arith_mc = (fmt_a && instruction_i[28])
             || (fmt_a && instruction_i[28:23] == 6'b000111)
             || (fmt_b && instruction_i[30:26] == 5'b00111);
    is_load  = instruction_i[29];
    vec      = fmt_c && (instruction_i[28:25] >= 4'b1010);
    stride   = {{(32-STRIDE_W){1'b0}}, instruction_i[15+STRIDE_W-1:15]};
  end

  // Requests are suppressed combinationally while reset is held so the
  // arbiter never sees a request from a strand that is being cleared.
  always_comb begin
    last               = (lane_q == LANE_W'(NUM_LANES-1)) && (state_q != CACHE_WAIT);
    issue_request_o    = !reset && instruction_valid_i && !flush_i
                         && (state_q != RAW_WAIT) && (state_q != CACHE_WAIT);
    will_issue         = issue_request_o && grant_i;
    in_vec             = (state_q == VLOAD) || (state_q == VSTORE) || vec;
    next_instruction_o = will_issue && (((state_q == NORMAL) && !vec) || (in_vec && last));
  end

  always_comb begin
    lane_d   = lane_q;
    offset_d = offset_q;
    if (suspend_strand_i) begin
      lane_d   = rollback_reg_lane_i;
      offset_d = rollback_strided_offset_i;
    end else if (flush_i || (will_issue && in_vec && last)) begin
      lane_d   = '0;
      offset_d = '0;
    end else if (will_issue && in_vec) begin
      lane_d   = lane_q + LANE_W'(1);
      offset_d = offset_q + stride;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      state_d = suspend_strand_i ? CACHE_WAIT : NORMAL;
    end else begin
      unique case (state_q)
        NORMAL: begin
          if (will_issue && vec && !last) begin
            state_d = is_load ? VLOAD : VSTORE;
          end else if (will_issue && fmt_c && is_load && !vec) begin
            state_d = RAW_WAIT;
            cnt_d   = CNT_W'(LOAD_LATENCY);
          end else if (will_issue && arith_mc) begin
            state_d = RAW_WAIT;
            cnt_d   = CNT_W'(ARITH_LATENCY);
          end
        end
        VLOAD: if (will_issue && last) begin
          state_d = RAW_WAIT;
          cnt_d   = CNT_W'(LOAD_LATENCY);
        end
        VSTORE:     if (will_issue && last) state_d = NORMAL;
        RAW_WAIT: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = NORMAL;
        end
        CACHE_WAIT: if (resume_strand_i) state_d = NORMAL;
        default:    state_d = NORMAL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= NORMAL;
      lane_q   <= '0;
      offset_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      offset_q <= offset_d;
      cnt_q    <= cnt_d;
    end
  end

  assign reg_lane_select_o = lane_q;
  assign strided_offset_o  = offset_q;
  assign pc_o              = pc_i;
  assign instruction_o     = instruction_i;
  assign strand_state_o    = state_q;

endmodule

// File: tb/tb_strand_fsm_param.sv
// Scoreboarded random bench for strand_fsm_param: two instances (16 lanes and
// 4 lanes with wide stride) driven in lockstep against a behavioural model.
module tb_strand_fsm_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, valid, grant, flush, susp, resume;
  logic [31:0] ins, pc, roff;
  logic [3:0]  rlane;

  logic        a_req, a_nxt, b_req, b_nxt;
  logic [3:0]  a_lane;
  logic [1:0]  b_lane;
  logic [31:0] a_off, b_off, a_pc, b_pc, a_ins, b_ins;
  logic [2:0]  a_st, b_st;

  strand_fsm_param #(.NUM_LANES(16), .LANE_W(4), .STRIDE_W(10),
                     .LOAD_LATENCY(2), .ARITH_LATENCY(3)) dut_a (
    .clk(clk), .reset(reset), .instruction_i(ins), .instruction_valid_i(valid),
    .pc_i(pc), .grant_i(grant), .flush_i(flush), .suspend_strand_i(susp),
    .resume_strand_i(resume), .rollback_reg_lane_i(rlane),
    .rollback_strided_offset_i(roff), .issue_request_o(a_req),
    .next_instruction_o(a_nxt), .reg_lane_select_o(a_lane),
    .strided_offset_o(a_off), .pc_o(a_pc), .instruction_o(a_ins),
    .strand_state_o(a_st));

  strand_fsm_param #(.NUM_LANES(4), .LANE_W(2), .STRIDE_W(14),
                     .LOAD_LATENCY(1), .ARITH_LATENCY(4)) dut_b (
    .clk(clk), .reset(reset), .instruction_i(ins), .instruction_valid_i(valid),
    .pc_i(pc), .grant_i(grant), .flush_i(flush), .suspend_strand_i(susp),
    .resume_strand_i(resume), .rollback_reg_lane_i(rlane[1:0]),
    .rollback_strided_offset_i(roff), .issue_request_o(b_req),
    .next_instruction_o(b_nxt), .reg_lane_select_o(b_lane),
    .strided_offset_o(b_off), .pc_o(b_pc), .instruction_o(b_ins),
    .strand_state_o(b_st));

  // Model state: mode 0 idle, 1 vector load, 2 vector store, 3 stalled on
  // RAW for 'wait_left' cycles, 4 parked on a cache miss.
  typedef struct {
    int          mode;
    int          lane;
    logic [31:0] off;
    int          wait_left;
  } mst_t;

  typedef struct {
    logic        req;
    logic        nxt;
    logic [31:0] lane;
    logic [31:0] off;
    logic [2:0]  st;
  } exp_t;

  typedef struct {
    exp_t        a;
    exp_t        b;
    logic [31:0] pc;
    logic [31:0] ins;
  } rec_t;

  rec_t scb[$];
  mst_t ma, mb;
  int   checks = 0;
  int   errors = 0;
  int   cyc_n  = 0;

  function automatic void mstep(input mst_t m, input int nl, input int sw,
                                input int ll, input int al, output exp_t e,
                                output mst_t n);
    logic fa, fb, fc, amc, ld, vec, last, wi, inv;
    logic [31:0] stride;
    n = m;
    if (reset) begin
      n = '{0, 0, 32'd0, 0};
      e = '{1'b0, 1'b0, 32'd0, 32'd0, 3'd0};
      return;
    end
    fa  = ins[31:29] == 3'b110;
    fb  = !ins[31];
    fc  = ins[31:30] == 2'b10;
    amc = (fa && ins[28]) || (fa && ins[28:23] == 6'b000111) || (fb && ins[30:26] == 5'b00111);
    ld  = ins[29];
    vec = fc && (ins[28:25] >= 4'd10);
    stride = (ins >> 15) & ((32'd1 << sw) - 32'd1);
    last = (m.lane == nl - 1) && (m.mode != 4);
    e.req  = valid && !flush && m.mode != 3 && m.mode != 4;
    wi     = e.req && grant;
    inv    = m.mode == 1 || m.mode == 2 || vec;
    e.nxt  = wi && ((m.mode == 0 && !vec) || (inv && last));
    e.lane = 32'(m.lane);
    e.off  = m.off;
    e.st   = 3'(m.mode);
    if (susp) begin
      n.lane = int'(rlane) % nl;
      n.off  = roff;
    end else if (flush || (wi && inv && last)) begin
      n.lane = 0;
      n.off  = 0;
    end else if (wi && inv) begin
      n.lane = m.lane + 1;
      n.off  = m.off + stride;
    end
    if (flush) n.mode = susp ? 4 : 0;
    else if (m.mode == 0) begin
      if (wi && vec && !last) n.mode = ld ? 1 : 2;
      else if (wi && fc && ld && !vec) begin n.mode = 3; n.wait_left = ll; end
      else if (wi && amc) begin n.mode = 3; n.wait_left = al; end
    end else if (m.mode == 1) begin
      if (wi && last) begin n.mode = 3; n.wait_left = ll; end
    end else if (m.mode == 2) begin
      if (wi && last) n.mode = 0;
    end else if (m.mode == 3) begin
      n.wait_left = m.wait_left - 1;
      if (m.wait_left == 1) n.mode = 0;
    end else if (resume) n.mode = 0;
  endfunction

  task automatic cyc(input logic v, input logic [31:0] i, input logic g,
                     input logic f, input logic s, input logic r,
                     input logic [3:0] rl, input logic [31:0] ro, input logic rs);
    rec_t rec;
    mst_t na, nb;
    @(posedge clk);
    #1;
    valid = v; ins = i; grant = g; flush = f; susp = s; resume = r;
    rlane = rl; roff = ro; reset = rs; pc = $urandom;
    mstep(ma, 16, 10, 2, 3, rec.a, na);
    mstep(mb, 4, 14, 1, 4, rec.b, nb);
    rec.pc = pc;
    rec.ins = ins;
    ma = na;
    mb = nb;
    scb.push_back(rec);
  endtask

  task automatic run(input logic [31:0] i, input int n, input logic g);
    for (int k = 0; k < n; k++) cyc(1'b1, i, g, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0);
  endtask

  function automatic void chk(input string name, input logic [31:0] got,
                              input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc_n, got, exp);
    end
  endfunction

  always @(negedge clk) begin
    rec_t r;
    cyc_n++;
    if (scb.size() > 0) begin
      r = scb.pop_front();
      chk("a_req",  32'(a_req),  32'(r.a.req));
      chk("a_nxt",  32'(a_nxt),  32'(r.a.nxt));
      chk("a_lane", 32'(a_lane), r.a.lane);
      chk("a_off",  a_off,       r.a.off);
      chk("a_st",   32'(a_st),   32'(r.a.st));
      chk("b_req",  32'(b_req),  32'(r.b.req));
      chk("b_nxt",  32'(b_nxt),  32'(r.b.nxt));
      chk("b_lane", 32'(b_lane), r.b.lane);
      chk("b_off",  b_off,       r.b.off);
      chk("b_st",   32'(b_st),   32'(r.b.st));
      chk("pc_o",   a_pc ^ b_pc ^ r.pc, r.pc);
      chk("ins_o",  a_ins ^ b_ins ^ r.ins, r.ins);
    end
  end

  function automatic logic [31:0] vins(input logic ld, input logic [9:0] s);
    return {2'b10, ld, 4'b1111, s, 15'h0};
  endfunction

  function automatic logic [31:0] rand_ins();
    case ($urandom_range(0, 5))
      0:       return {3'b101, 4'($urandom_range(0, 9)), 25'($urandom)};
      1:       return {3'b101, 4'($urandom_range(10, 15)), 25'($urandom)};
      2:       return {3'b100, 4'($urandom_range(10, 15)), 25'($urandom)};
      3:       return {3'b110, 29'($urandom)};
      4:       return {1'b0, 5'b00111, 26'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] cur;
    reset = 1'b1; valid = 0; grant = 0; flush = 0; susp = 0; resume = 0;
    ins = 0; pc = 0; rlane = 0; roff = 0;
    ma = '{0, 0, 32'd0, 0};
    mb = '{0, 0, 32'd0, 0};
    cyc(1'b1, vins(1'b1, 10'd8), 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1);
    cyc(1'b1, vins(1'b1, 10'd8), 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1);
    // scalar load, then RAW stall
    run({3'b101, 4'b0011, 25'h0}, 5, 1'b1);
    // vector load stride 8 with grant held
    run(vins(1'b1, 10'd8), 20, 1'b1);
    // vector store with grant dropped for three lanes
    run(vins(1'b0, 10'd4), 3, 1'b1);
    run(vins(1'b0, 10'd4), 3, 1'b0);
    run(vins(1'b0, 10'd4), 16, 1'b1);
    // flush+suspend mid-transfer, park, then resume from the rollback point
    run(vins(1'b1, 10'd8), 8, 1'b1);
    cyc(1'b1, vins(1'b1, 10'd8), 1'b1, 1'b1, 1'b1, 1'b1, 4'd5, 32'd40, 1'b0);
    run(vins(1'b1, 10'd8), 3, 1'b1);
    cyc(1'b1, vins(1'b1, 10'd8), 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 32'd0, 1'b0);
    run(vins(1'b1, 10'd8), 14, 1'b1);
    // long arithmetic stall, then reset mid vector load
    run({3'b110, 1'b1, 28'h0}, 6, 1'b1);
    run(vins(1'b1, 10'd3), 10, 1'b1);
    cyc(1'b1, vins(1'b1, 10'd3), 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1);
    // max 14-bit stride on the narrow instance
    run({3'b101, 14'h3FFF, 15'h0}, 8, 1'b1);
    cur = rand_ins();
    for (int n = 0; n < 4000; n++) begin
      logic f;
      if ($urandom_range(0, 5) == 0) cur = rand_ins();
      f = $urandom_range(0, 39) == 0;
      cyc($urandom_range(0, 9) != 0, cur, $urandom_range(0, 4) != 0, f,
          f && $urandom_range(0, 1) == 0, $urandom_range(0, 7) == 0,
          4'($urandom), $urandom, $urandom_range(0, 299) == 0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("scb_drained", 32'(scb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
